uart_receiver: RTL and testbench

Receive end of the team's single-clock UART link: deserialises the 8N1 bit stream driven by the UART transmitter (one bit per `clk`, idle high, start 0, 8 data bits LSB first, stop 1) into bytes. Each completed byte is held in an output register with a valid/acknowledge handshake. Framing errors and overruns are flagged. Sits directly on the transmitter's serial output (same clock domain) or on an already-synchronised external line.

---
 rtl/uart_receiver.sv | 128 ++++++++++++
 tb/tb_uart_receiver.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Deserialises an 8N1 bit-per-clock serial stream (idle high, start 0,
// eight data bits LSB first, stop 1) into bytes. Each good byte is held in
// dataOut with a valid/acknowledge handshake; bad stop bits and unread
// bytes that get overwritten are reported as one-cycle pulses.
//
// Ports
//   clk        in  1  single clock, rising edge
//   rst        in  1  synchronous, active-high reset
//   rxBit      in  1  serial line, idle level 1
//   dataAck    in  1  consumer accepts dataOut (only meaningful while dataValid)
//   dataOut    out 8  last correctly framed byte
//   dataValid  out 1  dataOut holds an unacknowledged byte
//   frameError out 1  pulse: stop bit sampled as 0
//   overrun    out 1  pulse: new byte completed while previous one unread
//   busy       out 1  receiver is not idle
// ---------------------------------------------------------------------------
module uart_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxBit,
  input  logic       dataAck,
  output logic [7:0] dataOut,
  output logic       dataValid,
  output logic       frameError,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    STOP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [7:0]  data_q,  data_d;
  logic        valid_q, valid_d;
  logic        ferr_q,  ferr_d;
  logic        ovr_q,   ovr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      cnt_q   <= 3'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    // An acknowledge retires the held byte; a good stop bit below may
    // immediately re-arm it with the new byte.
    valid_d = valid_q & ~dataAck;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // No glitch filter: the line is one bit per clock, so any low is a start bit.
        if (!rxBit) begin
          state_d = DATA;
          cnt_d   = 3'd0;
        end
      end

      DATA: begin
        // LSB arrives first, so shifting in from the top leaves it in bit 0.
        shift_d = {rxBit, shift_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = STOP;
        end
      end

      STOP: begin
        if (rxBit) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          // Overwriting a byte nobody accepted this edge loses it.
          ovr_d   = valid_q & ~dataAck;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = RECOVER;
        end
      end

      RECOVER: begin
        // A held-low (break) line must not be mistaken for a start bit.
        if (rxBit) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dataOut    = data_q;
  assign dataValid  = valid_q;
  assign frameError = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  logic       clk;
  logic       rst;
  logic       rxBit;
  logic       dataAck;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       frameError;
  logic       overrun;
  logic       busy;

  uart_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .rxBit      (rxBit),
    .dataAck    (dataAck),
    .dataOut    (dataOut),
    .dataValid  (dataValid),
    .frameError (frameError),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the consumer should see, updated per frame / per idle span.
  logic [7:0] exp_data;
  logic       exp_valid;
  int         exp_ferr;
  int         exp_ovr;
  int         exp_busy;

  // Observations gathered by the stimulus drivers.
  logic [7:0] obs_data;
  logic       obs_valid;
  logic [7:0] obs_data_pre;
  logic       obs_valid_pre;
  int         obs_ferr;
  int         obs_ovr;
  int         obs_busy;

  // Frame-level model: a frame is start + 8 data + stop with an ack pattern
  // (bit i = dataAck during frame cycle i, cycle 9 is the stop sample).
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic [9:0] ack);
    logic v_at_stop;
    v_at_stop = exp_valid && (ack[8:0] == 9'd0);
    exp_ferr  = stop ? 0 : 1;
    exp_ovr   = (stop && v_at_stop && !ack[9]) ? 1 : 0;
    exp_busy  = stop ? 9 : 10;
    if (stop) begin
      exp_data  = b;
      exp_valid = 1'b1;
    end else begin
      exp_valid = v_at_stop && !ack[9];
    end
  endtask

  // Line held at a constant level for n cycles; any ack retires a held byte.
  task automatic model_line(input int n, input logic [15:0] ack);
    for (int i = 0; i < n; i++) begin
      if (ack[i]) exp_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [9:0] ack);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    obs_ferr = 0; obs_ovr = 0; obs_busy = 0;
    for (int i = 0; i < 10; i++) begin
      rxBit   = bits[i];
      dataAck = ack[i];
      @(posedge clk); #1;
      obs_busy += int'(busy);
      obs_ferr += int'(frameError);
      obs_ovr  += int'(overrun);
      if (i == 8) begin
        obs_data_pre  = dataOut;
        obs_valid_pre = dataValid;
      end
    end
    obs_data  = dataOut;
    obs_valid = dataValid;
    dataAck   = 1'b0;
    rxBit     = 1'b1;
    $display("frame %02h stop=%0b ack=%03h -> dataOut=%02h valid=%0b ferr=%0d ovr=%0d busy=%0d",
             b, stop, ack, obs_data, obs_valid, obs_ferr, obs_ovr, obs_busy);
  endtask

  task automatic line_cycles(input int n, input logic level, input logic [15:0] ack);
    obs_ferr = 0; obs_ovr = 0; obs_busy = 0;
    for (int i = 0; i < n; i++) begin
      rxBit   = level;
      dataAck = ack[i];
      @(posedge clk); #1;
      obs_busy += int'(busy);
      obs_ferr += int'(frameError);
      obs_ovr  += int'(overrun);
    end
    obs_data  = dataOut;
    obs_valid = dataValid;
    dataAck   = 1'b0;
    rxBit     = 1'b1;
    $display("line level=%0b x%0d -> dataOut=%02h valid=%0b busy=%0d pulses=%0d",
             level, n, obs_data, obs_valid, obs_busy, obs_ferr + obs_ovr);
  endtask

  task automatic test_reset();
    rst = 1'b1; rxBit = 1'b1; dataAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (dataOut !== 8'h00)  begin n_err++; $display("FAIL reset_dataOut got %02h want 00", dataOut); end
    n_vec++; if (dataValid !== 1'b0) begin n_err++; $display("FAIL reset_dataValid got %0b want 0", dataValid); end
    n_vec++; if (frameError !== 1'b0) begin n_err++; $display("FAIL reset_frameError got %0b want 0", frameError); end
    n_vec++; if (overrun !== 1'b0)   begin n_err++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    $display("reset done");
    rst = 1'b0;
    exp_data = 8'h00; exp_valid = 1'b0;
    line_cycles(2, 1'b1, 16'h0);
  endtask

  task automatic test_single();
    model_frame(8'hA5, 1'b1, 10'h0);
    send_frame(8'hA5, 1'b1, 10'h0);
    n_vec++; if (obs_valid_pre !== 1'b0) begin n_err++; $display("FAIL single_valid_before_stop got %0b want 0", obs_valid_pre); end
    n_vec++; if (obs_data !== exp_data)  begin n_err++; $display("FAIL single_dataOut got %02h want %02h", obs_data, exp_data); end
    n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL single_dataValid got %0b want %0b", obs_valid, exp_valid); end
    n_vec++; if (obs_ferr !== exp_ferr)  begin n_err++; $display("FAIL single_frameError got %0d want %0d", obs_ferr, exp_ferr); end
    n_vec++; if (obs_ovr !== exp_ovr)    begin n_err++; $display("FAIL single_overrun got %0d want %0d", obs_ovr, exp_ovr); end
    n_vec++; if (obs_busy !== exp_busy)  begin n_err++; $display("FAIL single_busy_cycles got %0d want %0d", obs_busy, exp_busy); end
    model_line(3, 16'h0);
    line_cycles(3, 1'b1, 16'h0);
    n_vec++; if (obs_data !== 8'hA5 || obs_valid !== exp_valid)
      begin n_err++; $display("FAIL single_hold got %02h/%0b want a5/%0b", obs_data, obs_valid, exp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    model_line(1, 16'h1);
    line_cycles(1, 1'b1, 16'h1);
    n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL b2b_preack got %0b want %0b", obs_valid, exp_valid); end
    for (int k = 0; k < 3; k++) begin
      model_frame(bytes[k], 1'b1, 10'h0);
      send_frame(bytes[k], 1'b1, 10'h0);
      n_vec++; if (obs_data !== exp_data)   begin n_err++; $display("FAIL b2b_dataOut[%0d] got %02h want %02h", k, obs_data, exp_data); end
      n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL b2b_dataValid[%0d] got %0b want %0b", k, obs_valid, exp_valid); end
      n_vec++; if (obs_ovr !== exp_ovr)     begin n_err++; $display("FAIL b2b_overrun[%0d] got %0d want %0d", k, obs_ovr, exp_ovr); end
      model_line(1, 16'h1);
      line_cycles(1, 1'b1, 16'h1);
      n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL b2b_ack[%0d] got %0b want %0b", k, obs_valid, exp_valid); end
    end
  endtask

  task automatic test_overrun();
    model_frame(8'h12, 1'b1, 10'h0);
    send_frame(8'h12, 1'b1, 10'h0);
    n_vec++; if (obs_ovr !== exp_ovr) begin n_err++; $display("FAIL ovr_first got %0d want %0d", obs_ovr, exp_ovr); end
    model_line(1, 16'h0);
    line_cycles(1, 1'b1, 16'h0);
    model_frame(8'h34, 1'b1, 10'h0);
    send_frame(8'h34, 1'b1, 10'h0);
    n_vec++; if (obs_data !== exp_data)   begin n_err++; $display("FAIL ovr_dataOut got %02h want %02h", obs_data, exp_data); end
    n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL ovr_dataValid got %0b want %0b", obs_valid, exp_valid); end
    n_vec++; if (obs_ovr !== exp_ovr)     begin n_err++; $display("FAIL ovr_pulses got %0d want %0d", obs_ovr, exp_ovr); end
    model_line(1, 16'h1);
    line_cycles(1, 1'b1, 16'h1);
    n_vec++; if (obs_ovr !== 0) begin n_err++; $display("FAIL ovr_selfclear got %0d want 0", obs_ovr); end
  endtask

  task automatic test_same_edge_ack();
    model_frame(8'h12, 1'b1, 10'h0);
    send_frame(8'h12, 1'b1, 10'h0);
    model_line(1, 16'h0);
    line_cycles(1, 1'b1, 16'h0);
    model_frame(8'h34, 1'b1, 10'h200);
    send_frame(8'h34, 1'b1, 10'h200);
    n_vec++; if (obs_data !== exp_data)   begin n_err++; $display("FAIL same_ack_dataOut got %02h want %02h", obs_data, exp_data); end
    n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL same_ack_dataValid got %0b want %0b", obs_valid, exp_valid); end
    n_vec++; if (obs_ovr !== exp_ovr)     begin n_err++; $display("FAIL same_ack_overrun got %0d want %0d", obs_ovr, exp_ovr); end
    model_line(1, 16'h1);
    line_cycles(1, 1'b1, 16'h1);
  endtask

  task automatic test_frame_error();
    model_frame(8'h77, 1'b1, 10'h0);
    send_frame(8'h77, 1'b1, 10'h0);
    model_frame(8'h3C, 1'b0, 10'h0);
    send_frame(8'h3C, 1'b0, 10'h0);
    n_vec++; if (obs_ferr !== exp_ferr)   begin n_err++; $display("FAIL ferr_pulses got %0d want %0d", obs_ferr, exp_ferr); end
    n_vec++; if (obs_ovr !== exp_ovr)     begin n_err++; $display("FAIL ferr_overrun got %0d want %0d", obs_ovr, exp_ovr); end
    n_vec++; if (obs_data !== exp_data)   begin n_err++; $display("FAIL ferr_dataOut got %02h want %02h", obs_data, exp_data); end
    n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL ferr_dataValid got %0b want %0b", obs_valid, exp_valid); end
    n_vec++; if (obs_busy !== exp_busy)   begin n_err++; $display("FAIL ferr_busy got %0d want %0d", obs_busy, exp_busy); end
    model_line(5, 16'h0);
    line_cycles(5, 1'b0, 16'h0);
    n_vec++; if (obs_busy !== 5) begin n_err++; $display("FAIL break_busy got %0d want 5", obs_busy); end
    n_vec++; if (obs_ferr + obs_ovr !== 0) begin n_err++; $display("FAIL break_pulses got %0d want 0", obs_ferr + obs_ovr); end
    n_vec++; if (obs_data !== exp_data || obs_valid !== exp_valid)
      begin n_err++; $display("FAIL break_hold got %02h/%0b want %02h/%0b", obs_data, obs_valid, exp_data, exp_valid); end
    model_line(1, 16'h1);
    line_cycles(1, 1'b1, 16'h1);
    n_vec++; if (obs_busy !== 0) begin n_err++; $display("FAIL recover_exit_busy got %0d want 0", obs_busy); end
    model_frame(8'h81, 1'b1, 10'h0);
    send_frame(8'h81, 1'b1, 10'h0);
    n_vec++; if (obs_data !== exp_data)   begin n_err++; $display("FAIL after_ferr_dataOut got %02h want %02h", obs_data, exp_data); end
    n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL after_ferr_dataValid got %0b want %0b", obs_valid, exp_valid); end
    n_vec++; if (obs_ovr !== exp_ovr)     begin n_err++; $display("FAIL after_ferr_overrun got %0d want %0d", obs_ovr, exp_ovr); end
    model_line(1, 16'h1);
    line_cycles(1, 1'b1, 16'h1);
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    model_frame(8'h55, 1'b1, 10'h0);
    send_frame(8'h55, 1'b1, 10'h0);
    n_vec++; if (obs_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got %0b want 1", obs_valid); end
    bits = {1'b1, 8'hE7, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxBit = bits[i];
      @(posedge clk); #1;
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %0b want 1", busy); end
    rxBit = bits[5];
    rst   = 1'b1;
    @(posedge clk); #1;
    $display("reset at d4 -> dataOut=%02h valid=%0b ferr=%0b ovr=%0b busy=%0b",
             dataOut, dataValid, frameError, overrun, busy);
    n_vec++; if (dataOut !== 8'h00)   begin n_err++; $display("FAIL midrst_dataOut got %02h want 00", dataOut); end
    n_vec++; if (dataValid !== 1'b0)  begin n_err++; $display("FAIL midrst_dataValid got %0b want 0", dataValid); end
    n_vec++; if (frameError !== 1'b0 || overrun !== 1'b0)
      begin n_err++; $display("FAIL midrst_pulses got %0b%0b want 00", frameError, overrun); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL midrst_busy got %0b want 0", busy); end
    rst = 1'b0;
    exp_data = 8'h00; exp_valid = 1'b0;
    model_line(1, 16'h0);
    line_cycles(1, 1'b1, 16'h0);
    model_frame(8'hC3, 1'b1, 10'h0);
    send_frame(8'hC3, 1'b1, 10'h0);
    n_vec++; if (obs_data !== exp_data)   begin n_err++; $display("FAIL post_rst_dataOut got %02h want %02h", obs_data, exp_data); end
    n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL post_rst_dataValid got %0b want %0b", obs_valid, exp_valid); end
    n_vec++; if (obs_ovr !== exp_ovr)     begin n_err++; $display("FAIL post_rst_overrun got %0d want %0d", obs_ovr, exp_ovr); end
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic        stop;
    logic [9:0]  ack;
    logic [15:0] gap_ack;
    int          gap;
    for (int k = 0; k < 40; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      ack  = 10'($urandom & $urandom & $urandom);
      model_frame(b, stop, ack);
      send_frame(b, stop, ack);
      n_vec++; if (obs_data !== exp_data)   begin n_err++; $display("FAIL rnd%0d_dataOut got %02h want %02h", k, obs_data, exp_data); end
      n_vec++; if (obs_valid !== exp_valid) begin n_err++; $display("FAIL rnd%0d_dataValid got %0b want %0b", k, obs_valid, exp_valid); end
      n_vec++; if (obs_ferr !== exp_ferr)   begin n_err++; $display("FAIL rnd%0d_frameError got %0d want %0d", k, obs_ferr, exp_ferr); end
      n_vec++; if (obs_ovr !== exp_ovr)     begin n_err++; $display("FAIL rnd%0d_overrun got %0d want %0d", k, obs_ovr, exp_ovr); end
      n_vec++; if (obs_busy !== exp_busy)   begin n_err++; $display("FAIL rnd%0d_busy got %0d want %0d", k, obs_busy, exp_busy); end
      if (!stop) begin
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          model_line(gap, 16'h0);
          line_cycles(gap, 1'b0, 16'h0);
          n_vec++; if (obs_busy !== gap) begin n_err++; $display("FAIL rnd%0d_break_busy got %0d want %0d", k, obs_busy, gap); end
        end
        gap = 1;
      end else begin
        gap = $urandom_range(0, 2);
      end
      if (gap > 0) begin
        gap_ack = 16'($urandom);
        model_line(gap, gap_ack);
        line_cycles(gap, 1'b1, gap_ack);
        n_vec++; if (obs_valid !== exp_valid || obs_busy !== 0 || obs_ferr + obs_ovr !== 0)
          begin n_err++; $display("FAIL rnd%0d_idle got valid=%0b busy=%0d pulses=%0d want valid=%0b busy=0 pulses=0",
                                  k, obs_valid, obs_busy, obs_ferr + obs_ovr, exp_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_same_edge_ack();
    test_frame_error();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
